// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// default watchdog limit and the bit period shared with uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

  // 50 MHz / 115200 baud; uart_tx uses the same value so frame timing matches.
  localparam int CLOCK_BIT = 434;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning from ptr
// upward, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic               any,
  output logic [GW-1:0]      idx
);

  logic [GW-1:0] cand;

  // NOTE: every output of a combinational block gets a default on entry, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = GW'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers, with
// burst locking via req_last and a watchdog on the done handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int          NUM_REQ = 4,
  parameter int          GW      = 2,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_writedata,
  output logic                 tx_enable,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic                 timeout_err
);

  state_t             state, state_n;
  logic [GW-1:0]      rr_ptr, rr_ptr_n;
  logic [GW-1:0]      grant_n, pick_idx, pick_ptr, next_owner;
  logic               lock, lock_n;
  logic [15:0]        wdog, wdog_n;
  logic [NUM_REQ-1:0] ready_n, pick_req, owner_mask;
  logic [7:0]         wdata_n;
  logic               enable_n, terr_n, pick_any, accept, expire;

  // While a burst is locked only the owner may be picked.
  assign owner_mask = NUM_REQ'(1) << grant_id;
  assign pick_req   = (state == ST_HOLD) ? (req_valid & owner_mask) : req_valid;
  assign pick_ptr   = (state == ST_HOLD) ? grant_id : rr_ptr;
  assign next_owner = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
  assign expire     = (wdog == TIMEOUT - 16'd1);
  assign accept     = pick_any && ((state == ST_IDLE) || (state == ST_HOLD));

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    lock_n   = lock;
    wdog_n   = wdog;
    ready_n  = '0;
    enable_n = 1'b0;
    wdata_n  = tx_writedata;
    grant_n  = grant_id;
    terr_n   = 1'b0;

    case (state)
      ST_IDLE: state_n = ST_IDLE;
      ST_WAIT: begin
        wdog_n = wdog + 16'd1;
        // tx_done takes priority over a watchdog expiry in the same cycle.
        if (tx_done) begin
          if (lock) begin
            state_n = ST_HOLD;
            wdog_n  = '0;
          end else begin
            state_n  = ST_IDLE;
            rr_ptr_n = next_owner;
          end
        end else if (expire) begin
          state_n  = ST_IDLE;
          terr_n   = 1'b1;
          lock_n   = 1'b0;
          rr_ptr_n = next_owner;
        end
      end
      ST_HOLD: begin
        wdog_n = wdog + 16'd1;
        if (!pick_any && expire) begin
          state_n  = ST_IDLE;
          terr_n   = 1'b1;
          lock_n   = 1'b0;
          rr_ptr_n = next_owner;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (accept) begin
      state_n           = ST_WAIT;
      wdata_n           = req_data[{pick_idx, 3'b000} +: 8];
      enable_n          = 1'b1;
      ready_n[pick_idx] = 1'b1;
      grant_n           = pick_idx;
      lock_n            = ~req_last[pick_idx];
      wdog_n            = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      lock         <= 1'b0;
      wdog         <= '0;
      req_ready    <= '0;
      tx_writedata <= '0;
      tx_enable    <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_n;
      rr_ptr       <= rr_ptr_n;
      lock         <= lock_n;
      wdog         <= wdog_n;
      req_ready    <= ready_n;
      tx_writedata <= wdata_n;
      tx_enable    <= enable_n;
      busy         <= (state_n != ST_IDLE);
      grant_id     <= grant_n;
      timeout_err  <= terr_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requesters feed byte lists, expected
// grants are queued as stimulus is applied and popped on each tx_enable.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int          NUM_REQ = 4;
  localparam int          GW      = 2;
  localparam logic [15:0] TO      = 16'd20;

  logic                 clock;
  logic                 resetn;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_writedata;
  logic                 tx_enable;
  logic                 tx_done;
  logic                 busy;
  logic [GW-1:0]        grant_id;
  logic                 timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW),
    .TIMEOUT (TO)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_writedata (tx_writedata),
    .tx_enable    (tx_enable),
    .tx_done      (tx_done),
    .busy         (busy),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err)
  );

  typedef struct packed {
    logic [1:0] gid;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] src_mem [NUM_REQ][4];
  int         src_len [NUM_REQ];
  int         src_pos [NUM_REQ];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int mark_cyc    = 0;
  int last_en_cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time %0t, required finish earlier", $time);
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic add_src(input int i, input logic [7:0] data, input logic last);
    src_mem[i][src_len[i]] = {last, data};
    src_len[i]++;
  endtask

  task automatic expect_grant(input logic [1:0] gid, input logic [7:0] data);
    exp_t e;
    e.gid  = gid;
    e.data = data;
    sb.push_back(e);
  endtask

  // Requester i puts its next byte on the lines, or drops valid when empty.
  task automatic present(input int i);
    if (src_pos[i] < src_len[i]) begin
      req_valid[i]       = 1'b1;
      req_last[i]        = src_mem[i][src_pos[i]][8];
      req_data[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
      src_pos[i]++;
    end else begin
      req_valid[i] = 1'b0;
    end
  endtask

  // Wait for one transmit, compare it against the scoreboard head, then
  // optionally answer with a tx_done pulse on the following cycle.
  task automatic serve(input string tag, input bit do_done, input bit chk_gap, input int exp_gap);
    exp_t               e;
    logic [NUM_REQ-1:0] exp_ready;
    bit                 got;
    got = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (tx_enable === 1'b1) begin
        got = 1;
        break;
      end
    end
    check({tag, "_enable_seen"}, 32'(got), 1);
    if (!got) return;
    if (chk_gap) check({tag, "_gap"}, 32'(cyc - mark_cyc), 32'(exp_gap));
    check({tag, "_sb_pending"}, 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e         = sb.pop_front();
    exp_ready = NUM_REQ'(1) << e.gid;
    check({tag, "_grant"}, 32'(grant_id), 32'(e.gid));
    check({tag, "_data"},  32'(tx_writedata), 32'(e.data));
    check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    last_en_cyc = cyc;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i] === 1'b1) present(i);
    @(negedge clock);
    check({tag, "_enable_pulse"}, 32'(tx_enable), 0);
    check({tag, "_ready_pulse"},  32'(req_ready), 0);
    check({tag, "_busy"},         32'(busy), 1);
    if (do_done) begin
      tx_done  = 1'b1;
      mark_cyc = cyc;
      @(negedge clock);
      tx_done  = 1'b0;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    bit got;
    bit en_seen;
    resetn    = 1'b0;
    tx_done   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    clear_src();

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_wdata", 32'(tx_writedata), 0);
    check("rst_enable", 32'(tx_enable), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_terr", 32'(timeout_err), 0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    resetn = 1'b1;
    @(negedge clock);

    // Single byte from requester 2
    add_src(2, 8'hA5, 1'b1);
    expect_grant(2'd2, 8'hA5);
    present(2);
    mark_cyc = cyc;
    serve("single", 1'b1, 1'b1, 1);
    check("single_idle_busy", 32'(busy), 0);
    check("single_idle_state", 32'(dut.state), 32'(ST_IDLE));
    check("single_rr_ptr", 32'(dut.rr_ptr), 3);

    // Round-robin fairness from rr_ptr=0, requester 0 has a second byte
    do_reset();
    clear_src();
    for (int i = 0; i < NUM_REQ; i++) add_src(i, 8'h10 + 8'(i), 1'b1);
    add_src(0, 8'h50, 1'b1);
    expect_grant(2'd0, 8'h10);
    expect_grant(2'd1, 8'h11);
    expect_grant(2'd2, 8'h12);
    expect_grant(2'd3, 8'h13);
    expect_grant(2'd0, 8'h50);
    for (int i = 0; i < NUM_REQ; i++) present(i);
    serve("rr0", 1'b1, 1'b0, 0);
    for (int k = 1; k < 5; k++) serve($sformatf("rr%0d", k), 1'b1, 1'b1, 2);
    check("rr_done_busy", 32'(busy), 0);

    // Burst lock on requester 1 while requester 0 waits
    clear_src();
    add_src(1, 8'h11, 1'b0);
    add_src(1, 8'h22, 1'b0);
    add_src(1, 8'h33, 1'b1);
    add_src(0, 8'h77, 1'b1);
    expect_grant(2'd1, 8'h11);
    expect_grant(2'd1, 8'h22);
    expect_grant(2'd1, 8'h33);
    expect_grant(2'd0, 8'h77);
    present(1);
    present(0);
    serve("burst0", 1'b1, 1'b0, 0);
    serve("burst1", 1'b1, 1'b1, 2);
    serve("burst2", 1'b1, 1'b1, 2);
    serve("burst_next", 1'b1, 1'b1, 2);

    // WAIT timeout on requester 2, then grant moves on to requester 3
    clear_src();
    add_src(2, 8'h99, 1'b1);
    expect_grant(2'd2, 8'h99);
    present(2);
    serve("wto", 1'b0, 1'b0, 0);
    got = 0;
    for (int n = 0; n < 60; n++) begin
      if (timeout_err === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clock);
    end
    check("wto_seen", 32'(got), 1);
    check("wto_latency", 32'(cyc - last_en_cyc), 32'(TO));
    check("wto_busy", 32'(busy), 0);
    @(negedge clock);
    check("wto_pulse", 32'(timeout_err), 0);
    add_src(3, 8'h3A, 1'b1);
    add_src(0, 8'h0A, 1'b1);
    expect_grant(2'd3, 8'h3A);
    expect_grant(2'd0, 8'h0A);
    present(3);
    present(0);
    serve("wto_next", 1'b1, 1'b0, 0);
    serve("wto_wrap", 1'b1, 1'b1, 2);

    // tx_done in the same cycle as WAIT expiry: done wins, no error
    clear_src();
    add_src(1, 8'h5A, 1'b1);
    expect_grant(2'd1, 8'h5A);
    present(1);
    serve("race", 1'b0, 1'b0, 0);
    while (cyc < last_en_cyc + int'(TO) - 1) @(negedge clock);
    tx_done = 1'b1;
    @(negedge clock);
    tx_done = 1'b0;
    check("race_no_terr", 32'(timeout_err), 0);
    check("race_busy", 32'(busy), 0);
    check("race_rr_ptr", 32'(dut.rr_ptr), 2);
    @(negedge clock);
    check("race_no_terr_late", 32'(timeout_err), 0);

    // HOLD timeout: requester 3 locks then goes quiet; requester 0 must wait
    clear_src();
    add_src(3, 8'hC3, 1'b0);
    add_src(0, 8'hD0, 1'b1);
    expect_grant(2'd3, 8'hC3);
    expect_grant(2'd0, 8'hD0);
    present(3);
    present(0);
    serve("hto", 1'b1, 1'b0, 0);
    got     = 0;
    en_seen = 0;
    for (int n = 0; n < 60; n++) begin
      if (timeout_err === 1'b1) begin
        got = 1;
        break;
      end
      if (tx_enable === 1'b1) en_seen = 1;
      @(negedge clock);
    end
    check("hto_seen", 32'(got), 1);
    check("hto_latency", 32'(cyc - mark_cyc), 32'(TO) + 1);
    check("hto_no_other_grant", 32'(en_seen), 0);
    check("hto_lock", 32'(dut.lock), 0);
    check("hto_busy", 32'(busy), 0);
    mark_cyc = cyc;
    serve("hto_next", 1'b1, 1'b1, 1);

    // Reset while a byte is in flight
    clear_src();
    add_src(2, 8'hE2, 1'b1);
    expect_grant(2'd2, 8'hE2);
    present(2);
    serve("mid", 1'b0, 1'b0, 0);
    add_src(0, 8'h0F, 1'b1);
    add_src(3, 8'h3F, 1'b1);
    present(0);
    present(3);
    resetn = 1'b0;
    @(negedge clock);
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_wdata", 32'(tx_writedata), 0);
    check("mid_rst_enable", 32'(tx_enable), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_grant", 32'(grant_id), 0);
    check("mid_rst_terr", 32'(timeout_err), 0);
    check("mid_rst_rr_ptr", 32'(dut.rr_ptr), 0);
    check("mid_rst_wdog", 32'(dut.wdog), 0);
    resetn = 1'b1;
    expect_grant(2'd0, 8'h0F);
    expect_grant(2'd3, 8'h3F);
    serve("mid_first", 1'b1, 1'b0, 0);
    serve("mid_second", 1'b1, 1'b1, 2);

    check("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
